// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC register and the F/D pipeline latch.
// Holds the PC at RESET_PC for BOOT_CYCLES after reset so the instruction
// memory can warm up, then fetches sequentially. A redirect from X always
// wins over a stall, since the stalled F/D entry is on the wrong path.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int unsigned BOOT_CYCLES = 2,
  parameter logic [31:0] NOP         = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        branch_or_jump_pc,
  input  logic        stall,
  input  logic [31:0] q_imem,
  output logic [31:0] address_imem,
  output logic [31:0] fd_out_pc,
  output logic [31:0] fd_out_ir,
  output logic        fd_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [31:0] BOOT_LAST = 32'(BOOT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] boot_cnt_q, boot_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic [31:0] fd_ir_q, fd_ir_d;
  logic        fd_valid_q, fd_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] flush_count_q, flush_count_d;
  logic [31:0] pc_plus_one;

  assign pc_plus_one = pc_q + 32'd1;

  // Next-state: boot countdown, then redirect > stall > sequential fetch.
  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    pc_d          = pc_q;
    fd_pc_d       = fd_pc_q;
    fd_ir_d       = fd_ir_q;
    fd_valid_d    = fd_valid_q;
    fetch_count_d = fetch_count_q;
    flush_count_d = flush_count_q;
    case (state_q)
      ST_BOOT: begin
        boot_cnt_d = boot_cnt_q + 32'd1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (branch_or_jump_pc) begin
          pc_d          = next_pc;
          fd_pc_d       = 32'd0;
          fd_ir_d       = NOP;
          fd_valid_d    = 1'b0;
          flush_count_d = flush_count_q + 32'd1;
        end else if (!stall) begin
          pc_d          = pc_plus_one;
          fd_pc_d       = pc_plus_one;
          fd_ir_d       = q_imem;
          fd_valid_d    = 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State registers; reset returns immediately to BOOT with an empty F/D.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      boot_cnt_q    <= 32'd0;
      pc_q          <= RESET_PC;
      fd_pc_q       <= 32'd0;
      fd_ir_q       <= NOP;
      fd_valid_q    <= 1'b0;
      fetch_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      boot_cnt_q    <= boot_cnt_d;
      pc_q          <= pc_d;
      fd_pc_q       <= fd_pc_d;
      fd_ir_q       <= fd_ir_d;
      fd_valid_q    <= fd_valid_d;
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign address_imem = pc_q;
  assign fd_out_pc    = fd_pc_q;
  assign fd_out_ir    = fd_ir_q;
  assign fd_valid     = fd_valid_q;
  assign fetch_count  = fetch_count_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot delay, straight-line fetch, stall,
// redirect, redirect-over-stall, PC wrap and asynchronous reset mid-run.
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic [31:0] next_pc;
  logic        branch_or_jump_pc;
  logic        stall;
  logic [31:0] q_imem;
  logic [31:0] address_imem;
  logic [31:0] fd_out_pc;
  logic [31:0] fd_out_ir;
  logic        fd_valid;
  logic [31:0] fetch_count;
  logic [31:0] flush_count;

  int checkCount = 0;
  int failCount  = 0;

  fetch_stage #(
    .RESET_PC   (32'd0),
    .BOOT_CYCLES(2),
    .NOP        (32'd0)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .next_pc          (next_pc),
    .branch_or_jump_pc(branch_or_jump_pc),
    .stall            (stall),
    .q_imem           (q_imem),
    .address_imem     (address_imem),
    .fd_out_pc        (fd_out_pc),
    .fd_out_ir        (fd_out_ir),
    .fd_valid         (fd_valid),
    .fetch_count      (fetch_count),
    .flush_count      (flush_count)
  );

  // Instruction memory stand-in: the word at each address is address+100.
  assign q_imem = address_imem + 32'd100;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive the control inputs, then advance to just after the next rising edge.
  task automatic applyStimulus(input logic br, input logic [31:0] npc, input logic st);
    branch_or_jump_pc = br;
    next_pc           = npc;
    stall             = st;
    @(posedge clock);
    #1;
  endtask

  // Check the full F/D and PC picture in one call.
  task automatic checkState(input string tag, input logic [31:0] addr, input logic valid,
                            input logic [31:0] fpc, input logic [31:0] fir,
                            input logic [31:0] fcnt, input logic [31:0] lcnt);
    checkOutput({tag, ".addr"}, address_imem, addr);
    checkOutput({tag, ".valid"}, {31'd0, fd_valid}, {31'd0, valid});
    checkOutput({tag, ".fd_pc"}, fd_out_pc, fpc);
    checkOutput({tag, ".fd_ir"}, fd_out_ir, fir);
    checkOutput({tag, ".fetch_cnt"}, fetch_count, fcnt);
    checkOutput({tag, ".flush_cnt"}, flush_count, lcnt);
  endtask

  initial begin
    reset             = 1'b1;
    stall             = 1'b0;
    branch_or_jump_pc = 1'b0;
    next_pc           = 32'd0;
    #12;
    checkState("reset", 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    reset = 1'b0;

    // Boot: two edges with nothing latched, first fetch on the third edge.
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkState("boot1", 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkState("boot2", 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkState("first", 32'd1, 1'b1, 32'd1, 32'd100, 32'd1, 32'd0);

    // Straight line: words 101..104 at PC+1 = 2..5.
    for (int i = 2; i <= 5; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkState("seq", 32'(i), 1'b1, 32'(i), 32'(99 + i), 32'(i), 32'd0);
    end

    // Stall three cycles at PC=5: everything holds.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkState("stall", 32'd5, 1'b1, 32'd5, 32'd104, 32'd5, 32'd0);
    end
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkState("resume", 32'd6, 1'b1, 32'd6, 32'd105, 32'd6, 32'd0);

    // Redirect to 0x40: bubble, then the target lands in F/D.
    applyStimulus(1'b1, 32'h40, 1'b0);
    checkOutput("redir.addr", address_imem, 32'h40);
    checkOutput("redir.valid", {31'd0, fd_valid}, 32'd0);
    checkOutput("redir.fd_ir", fd_out_ir, 32'd0);
    checkOutput("redir.flush_cnt", flush_count, 32'd1);
    checkOutput("redir.fetch_cnt", fetch_count, 32'd6);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkState("target", 32'h41, 1'b1, 32'h41, 32'h40 + 32'd100, 32'd7, 32'd1);

    // Redirect and stall together: the redirect wins.
    applyStimulus(1'b1, 32'h80, 1'b1);
    checkOutput("rs.addr", address_imem, 32'h80);
    checkOutput("rs.valid", {31'd0, fd_valid}, 32'd0);
    checkOutput("rs.fd_ir", fd_out_ir, 32'd0);
    checkOutput("rs.fetch_cnt", fetch_count, 32'd7);
    checkOutput("rs.flush_cnt", flush_count, 32'd2);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("rs_hold.addr", address_imem, 32'h80);
    checkOutput("rs_hold.valid", {31'd0, fd_valid}, 32'd0);
    checkOutput("rs_hold.fetch_cnt", fetch_count, 32'd7);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkState("rs_fetch", 32'h81, 1'b1, 32'h81, 32'h80 + 32'd100, 32'd8, 32'd2);

    // PC wrap: redirect to all-ones, next fetch address and PC+1 are 0.
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0);
    checkOutput("wrap.addr", address_imem, 32'hFFFF_FFFF);
    checkOutput("wrap.flush_cnt", flush_count, 32'd3);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkState("wrapped", 32'd0, 1'b1, 32'd0, 32'd99, 32'd9, 32'd3);

    // Asynchronous reset between edges with stall and redirect pending.
    branch_or_jump_pc = 1'b1;
    next_pc           = 32'h200;
    stall             = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    checkState("async_rst", 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkState("reboot1", 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    applyStimulus(1'b1, 32'h300, 1'b0);
    checkState("reboot2", 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkState("reboot3", 32'd1, 1'b1, 32'd1, 32'd100, 32'd1, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
